imem_loader: RTL
================

# imem_loader

Program loader that writes the instruction memory's write port from a byte stream. It sits between a serial/host byte source and the instruction memory, and holds the core in reset-hold until a complete program has been written. After that the fetch side reads the memory by `pc` exactly as before. Stream format: a 16-bit little-endian word count, then that many 32-bit instructions, each sent least-significant byte first.

## Interface
Parameters:
- `ADDR_W`, 10: instruction memory address width.
- `DEPTH`, 1024: number of instruction words; a count above this is an error.

Ports:
- `clk`, in, 1: single clock; everything is on the rising edge.
- `reset`, in, 1: synchronous, active-high.
- `start`, in, 1: one-cycle pulse that begins a load. Honoured only in IDLE or DONE.
- `in_valid`, in, 1: byte available.
- `in_data`, in, 8: stream byte.
- `in_ready`, out, 1: loader accepts a byte this cycle. A transfer occurs when `in_valid & in_ready`.
- `mem_we`, out, 1: one-cycle write strobe to the instruction memory.
- `mem_addr`, out, ADDR_W: word address for the write.
- `mem_wdata`, out, 32: instruction word.
- `busy`, out, 1: load in progress.
- `done`, out, 1: load finished; held until the next `start` or `reset`.
- `err`, out, 1: word count exceeded DEPTH; valid while `done`.
- `words_loaded`, out, ADDR_W+1: number of words written so far.
- `core_hold`, out, 1: keeps the core from fetching. Low only in DONE with `err`=0.

## Operation
- FSM states: IDLE, LEN_LO, LEN_HI, DATA, WRITE, DONE.
- IDLE -> LEN_LO on `start`. Clears `words_loaded`, the byte index and `err`.
- LEN_LO: capture `count[7:0]`, go to LEN_HI.
- LEN_HI: capture `count[15:8]`, then branch on `count`:
  - `count` = 0: go to DONE, `err`=0.
  - `count` > DEPTH: go to DONE, `err`=1, no writes.
  - otherwise: go to DATA.
- DATA: byte index 0..3 selects the lane; byte k goes to `wdata[8k+7:8k]`. On the 4th accepted byte, go to WRITE.
- WRITE: `mem_we`=1 with `mem_addr`=`words_loaded[ADDR_W-1:0]` and the assembled word. Then `words_loaded`+1 and the byte index resets to 0. Next state is DONE if `words_loaded`+1 equals `count`, otherwise DATA.
- DONE: `start` goes to LEN_LO (a reload). All other inputs are ignored.
- `in_ready` = 1 in LEN_LO, LEN_HI and DATA; 0 in IDLE, WRITE and DONE. Bytes offered while `in_ready`=0 are not consumed.
- `busy` = 1 in LEN_LO, LEN_HI, DATA and WRITE.
- `start` while `busy` is ignored.
- Address arithmetic: `words_loaded` is ADDR_W+1 bits so that DEPTH is representable. `mem_addr` never wraps, because `count` ≤ DEPTH is guaranteed before the first write.

## Timing
- Reset values:
  - state = IDLE
  - `in_ready`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0
  - `busy`=0, `done`=0, `err`=0, `words_loaded`=0
  - `core_hold`=1
- Reset mid-load returns to IDLE with the values above. Memory contents already written are left as-is and treated as don't-care.
- `start` is sampled at edge N; `in_ready` is 1 from cycle N+1.
- Per word, `mem_we` rises the cycle after the 4th byte is accepted and lasts exactly one cycle.
- Peak throughput is 4 bytes per 5 cycles, with one bubble for WRITE.
- `done` and `core_hold`=0 take effect in the cycle after the final WRITE.
- An error is flagged in the cycle after LEN_HI is accepted.
- A byte that is valid with no gaps is accepted on back-to-back cycles; `in_valid` gaps simply stall the FSM.

## Structure
- Package `imem_loader_pkg`:
  - state enum
  - `DEPTH` / `ADDR_W` defaults
  - the 16-bit count width constant
- Sub-module `byte_packer`: 2-bit index plus 4x8 shift/lane register. It accepts bytes and outputs `word` and `full`. The FSM owns `count`, `words_loaded` and the strobes.

## Test plan
- Basic load: `start`, then bytes `02 00 | 13 05 10 00 | 93 05 15 00`.
  - Writes `mem[0]`=0x00100513 and `mem[1]`=0x00150593, each as a single `mem_we` pulse.
  - Then `done`=1, `core_hold`=0, `words_loaded`=2.
- Zero count: bytes `00 00`.
  - `done`=1 the next cycle, `err`=0, no `mem_we`.
- Oversize: bytes `01 04` (count 1025).
  - `done`=1, `err`=1, `core_hold`=1, no `mem_we`.
- Stalls and back-pressure: random `in_valid` gaps on a 3-word load.
  - Identical writes to the no-gap case.
  - Bytes presented during WRITE are held and consumed next cycle.
- Reset mid-word: assert `reset` after byte 2 of word 1.
  - All outputs return to reset values.
  - A new `start` with a 1-word load writes `mem[0]` correctly.
- Full depth: count 0x0400.
  - Final write is at `mem_addr`=1023, `words_loaded`=1024, `done`=1.
  - `start` during the load is ignored; `start` in DONE begins a reload.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory program loader.
// The stream header carries a 16-bit little-endian word count.
package imem_loader_pkg;

  localparam int ADDR_W_DEF = 10;
  localparam int DEPTH_DEF  = 1024;
  localparam int CNT_W      = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN_LO,
    ST_LEN_HI,
    ST_DATA,
    ST_WRITE,
    ST_DONE
  } state_t;

  // A count above the memory depth is rejected before any write happens.
  function automatic logic count_exceeds(input logic [CNT_W-1:0] cnt,
                                         input int unsigned depth);
    return 32'(cnt) > depth;
  endfunction

endpackage

// File: rtl/byte_packer.sv
// Assembles four stream bytes into a 32-bit word, least-significant byte first.
// `full` flags the push that completes the current word.
module byte_packer (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        push,
  input  logic [7:0]  din,
  output logic [31:0] word,
  output logic        full
);

  logic [1:0]      idx;
  logic [3:0][7:0] lanes;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      idx <= 2'd0;
    end else if (push) begin
      idx <= idx + 2'd1;
    end
  end

  // Lane contents are only observed once all four lanes are rewritten.
  always_ff @(posedge clk) begin
    if (push) begin
      lanes[idx] <= din;
    end
  end

  assign word = lanes;
  assign full = push && (idx == 2'd3);

endmodule

// File: rtl/imem_loader.sv
// Streams a length-prefixed program into the instruction memory write port
// and holds the core in reset until a valid program has been fully written.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   words_loaded,
  output logic              core_hold
);

  state_t           state, state_n;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_full;
  logic [ADDR_W:0]  wl_q;
  logic [ADDR_W:0]  wl_inc;
  logic             err_q;
  logic             accept;
  logic             last_word;

  logic             start_load;
  logic             ld_lo;
  logic             ld_hi;
  logic             push;
  logic             inc;
  logic             set_err;

  logic [31:0]      pk_word;
  logic             pk_full;

  assign accept     = in_valid && in_ready;
  assign count_full = {in_data, count[7:0]};
  assign wl_inc     = wl_q + {{ADDR_W{1'b0}}, 1'b1};
  assign last_word  = (CNT_W'(wl_inc) == count);

  always_comb begin
    state_n    = state;
    start_load = 1'b0;
    ld_lo      = 1'b0;
    ld_hi      = 1'b0;
    push       = 1'b0;
    inc        = 1'b0;
    set_err    = 1'b0;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          start_load = 1'b1;
          state_n    = ST_LEN_LO;
        end
      end
      ST_LEN_LO: begin
        if (accept) begin
          ld_lo   = 1'b1;
          state_n = ST_LEN_HI;
        end
      end
      ST_LEN_HI: begin
        if (accept) begin
          ld_hi = 1'b1;
          if (count_full == '0) begin
            state_n = ST_DONE;
          end else if (count_exceeds(count_full, DEPTH)) begin
            set_err = 1'b1;
            state_n = ST_DONE;
          end else begin
            state_n = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        if (accept) begin
          push = 1'b1;
          if (pk_full) begin
            state_n = ST_WRITE;
          end
        end
      end
      ST_WRITE: begin
        inc     = 1'b1;
        state_n = last_word ? ST_DONE : ST_DATA;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wl_q  <= '0;
      err_q <= 1'b0;
    end else begin
      if (start_load) begin
        wl_q  <= '0;
        err_q <= 1'b0;
      end else if (inc) begin
        wl_q <= wl_inc;
      end
      if (set_err) begin
        err_q <= 1'b1;
      end
    end
  end

  // The count is only read after both header bytes have been captured.
  always_ff @(posedge clk) begin
    if (ld_lo) begin
      count[7:0] <= in_data;
    end
    if (ld_hi) begin
      count[15:8] <= in_data;
    end
  end

  byte_packer u_packer (
    .clk  (clk),
    .rst  (reset),
    .clr  (start_load || inc),
    .push (push),
    .din  (in_data),
    .word (pk_word),
    .full (pk_full)
  );

  assign in_ready     = (state == ST_LEN_LO) || (state == ST_LEN_HI) || (state == ST_DATA);
  assign mem_we       = (state == ST_WRITE);
  assign mem_addr     = wl_q[ADDR_W-1:0];
  // Gate the data bus so it reads zero whenever no write is in flight.
  assign mem_wdata    = mem_we ? pk_word : 32'd0;
  assign busy         = in_ready || mem_we;
  assign done         = (state == ST_DONE);
  assign err          = err_q;
  assign words_loaded = wl_q;
  assign core_hold    = !(done && !err_q);

endmodule
